// File: rtl/omem_result_drain.sv
// rtl/omem_result_drain.sv - walks GPU O-memory of selected cores and streams each word to the host
//
// Purpose: when the GPU commits results, read every word (0..count-1) of every
// core selected in the mask through the GPU's O-memory read port, and present
// each word on a valid/ready stream. A one-cycle done strobe closes each drain.
//
// Ports:
//   Clock, Reset               clock, asynchronous active-low reset
//   iEnable                    gates new commit start events
//   iCoreMask, iWordCount      drain parameters, sampled when a drain starts
//   iGPUCommitedResults        commit level from the GPU (rising edge starts a drain)
//   oOMEMBankSelect            O-memory bank (core) select to the GPU
//   oOMEMReadAddress           O-memory word address to the GPU
//   iOMEMData                  O-memory read data, valid one cycle after the address
//   oResultData/Core/Address   drained word and where it came from
//   oResultValid, iResultReady host stream handshake
//   oBusy                      drain in progress
//   oDrainDone                 one-cycle completion pulse
module omem_result_drain #(
  parameter int WB_WIDTH      = 32,
  parameter int MAX_CORES     = 4,
  parameter int MAX_CORE_BITS = 2
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     iEnable,
  input  logic [MAX_CORES-1:0]     iCoreMask,
  input  logic [WB_WIDTH-1:0]      iWordCount,
  input  logic                     iGPUCommitedResults,
  output logic [MAX_CORE_BITS-1:0] oOMEMBankSelect,
  output logic [WB_WIDTH-1:0]      oOMEMReadAddress,
  input  logic [WB_WIDTH-1:0]      iOMEMData,
  output logic [WB_WIDTH-1:0]      oResultData,
  output logic [MAX_CORE_BITS-1:0] oResultCore,
  output logic [WB_WIDTH-1:0]      oResultAddress,
  output logic                     oResultValid,
  input  logic                     iResultReady,
  output logic                     oBusy,
  output logic                     oDrainDone
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_ISSUE, S_CAPTURE, S_PUSH, S_DONE
  } state_t;

  state_t                   state, state_nx;
  logic                     commit_q;
  logic                     pending;
  logic [MAX_CORES-1:0]     mask;
  logic [WB_WIDTH-1:0]      count;
  logic [WB_WIDTH-1:0]      addr;
  logic [MAX_CORE_BITS-1:0] core;

  logic                     start;
  logic                     restart;
  logic                     scan_hit;
  logic [MAX_CORE_BITS-1:0] scan_idx;
  logic                     scan_end;
  logic                     last_word;
  logic                     last_core;

  assign start     = iEnable & iGPUCommitedResults & ~commit_q;
  // A commit arriving in the DONE cycle itself is folded into the restart
  // so it is not lost while pending has not been registered yet.
  assign restart   = pending | start;
  assign scan_end  = (count == '0) | ~scan_hit;
  // Only evaluated in PUSH, where SCAN has already guaranteed count != 0.
  assign last_word = (addr == count - WB_WIDTH'(1));
  assign last_core = (core == MAX_CORE_BITS'(MAX_CORES - 1));

  // Lowest set mask bit at or above the current core; the descending loop
  // leaves the lowest qualifying index as the final assignment.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = MAX_CORES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(core))) begin
        scan_hit = 1'b1;
        scan_idx = MAX_CORE_BITS'(i);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    oResultValid     = 1'b0;
    oBusy            = 1'b1;
    oDrainDone       = 1'b0;
    oOMEMBankSelect  = '0;
    oOMEMReadAddress = '0;
    case (state)
      S_IDLE: begin
        oBusy = 1'b0;
        if (start) state_nx = S_SCAN;
      end
      S_SCAN:    state_nx = scan_end ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        oOMEMBankSelect  = core;
        oOMEMReadAddress = addr;
        state_nx         = S_CAPTURE;
      end
      S_CAPTURE: state_nx = S_PUSH;
      S_PUSH: begin
        oResultValid = 1'b1;
        if (iResultReady) begin
          if (!last_word)     state_nx = S_ISSUE;
          else if (last_core) state_nx = S_DONE;
          else                state_nx = S_SCAN;
        end
      end
      S_DONE: begin
        oDrainDone = 1'b1;
        state_nx   = restart ? S_SCAN : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      commit_q       <= 1'b0;
      pending        <= 1'b0;
      mask           <= '0;
      count          <= '0;
      addr           <= '0;
      core           <= '0;
      oResultData    <= '0;
      oResultCore    <= '0;
      oResultAddress <= '0;
    end else begin
      commit_q <= iGPUCommitedResults;
      // Extra commits during a drain collapse into a single pending flag.
      if (state == S_DONE)
        pending <= 1'b0;
      else if (start && state != S_IDLE)
        pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            mask  <= iCoreMask;
            count <= iWordCount;
            core  <= '0;
          end
        end
        S_SCAN: begin
          if (!scan_end) begin
            core <= scan_idx;
            addr <= '0;
          end
        end
        S_CAPTURE: begin
          oResultData    <= iOMEMData;
          oResultCore    <= core;
          oResultAddress <= addr;
        end
        S_PUSH: begin
          if (iResultReady) begin
            if (!last_word)      addr <= addr + WB_WIDTH'(1);
            else if (!last_core) core <= core + MAX_CORE_BITS'(1);
          end
        end
        S_DONE: begin
          if (restart) begin
            mask  <= iCoreMask;
            count <= iWordCount;
            core  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_omem_result_drain.sv
// tb/tb_omem_result_drain.sv - self-checking bench for omem_result_drain
module tb_omem_result_drain;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iEnable;
  logic [3:0]  iCoreMask;
  logic [31:0] iWordCount;
  logic        iGPUCommitedResults;
  logic [1:0]  oOMEMBankSelect;
  logic [31:0] oOMEMReadAddress;
  logic [31:0] iOMEMData = '0;
  logic [31:0] oResultData;
  logic [1:0]  oResultCore;
  logic [31:0] oResultAddress;
  logic        oResultValid;
  logic        iResultReady;
  logic        oBusy;
  logic        oDrainDone;

  omem_result_drain #(.WB_WIDTH(32), .MAX_CORES(4), .MAX_CORE_BITS(2)) dut (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iCoreMask(iCoreMask),
    .iWordCount(iWordCount), .iGPUCommitedResults(iGPUCommitedResults),
    .oOMEMBankSelect(oOMEMBankSelect), .oOMEMReadAddress(oOMEMReadAddress),
    .iOMEMData(iOMEMData), .oResultData(oResultData), .oResultCore(oResultCore),
    .oResultAddress(oResultAddress), .oResultValid(oResultValid),
    .iResultReady(iResultReady), .oBusy(oBusy), .oDrainDone(oDrainDone)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] count;
    int          rmode;
    int          beats;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          ready_mode = 0;
  logic [31:0] seed = 32'h1234_5678;
  beat_t       exp_q[$];
  int          beat_q[$];
  int          done_q[$];
  int          busy_cnt, busy_first, busy_last;
  vec_t        vecs[6];

  always @(posedge Clock) cyc <= cyc + 1;

  // O-memory contents as a pure function of (core, address, seed).
  function automatic logic [31:0] omem_word(input logic [1:0] c, input logic [31:0] a);
    return seed ^ {c, 30'h0} ^ (a * 32'h9E37_79B9) ^ 32'h00C0_FFEE;
  endfunction

  // GPU read port: data appears one cycle after the address.
  always @(posedge Clock) iOMEMData <= omem_word(oOMEMBankSelect, oOMEMReadAddress);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every selected core in ascending order, every word in order.
  task automatic add_expected(input logic [3:0] m, input logic [31:0] n);
    beat_t b;
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        for (int a = 0; a < int'(n); a++) begin
          b.c = 2'(c);
          b.a = 32'(a);
          b.d = omem_word(2'(c), 32'(a));
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // Ready driver.
  initial begin
    logic r;
    r = 1'b1;
    iResultReady = 1'b1;
    forever begin
      @(posedge Clock); #1;
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = ~r;
        2:       r = 1'($urandom_range(0, 1));
        default: r = 1'b0;
      endcase
      iResultReady = r;
    end
  end

  // Stream monitor / scoreboard.
  initial begin
    logic held;
    beat_t e;
    held = 1'b0;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        held = 1'b0;
      end else begin
        if (oBusy) begin
          busy_cnt++;
          if (busy_first < 0) busy_first = cyc;
          busy_last = cyc;
        end
        if (oDrainDone) done_q.push_back(cyc);
        if (held) check("hold_valid", 32'(oResultValid), 32'd1);
        if (oResultValid) begin
          if (exp_q.size() == 0) begin
            check("extra_valid", 32'(oResultValid), 32'd0);
          end else begin
            e = exp_q[0];
            check("beat_core", 32'(oResultCore), 32'(e.c));
            check("beat_addr", oResultAddress, e.a);
            check("beat_data", oResultData, e.d);
            if (iResultReady) begin
              void'(exp_q.pop_front());
              beat_q.push_back(cyc);
            end
          end
        end
        held = oResultValid & ~iResultReady;
      end
    end
  end

  task automatic begin_obs();
    exp_q.delete();
    beat_q.delete();
    done_q.delete();
    busy_cnt   = 0;
    busy_first = -1;
    busy_last  = -1;
    seed       = $urandom;
  endtask

  task automatic pulse_commit(output int t0);
    @(posedge Clock); #1;
    iGPUCommitedResults = 1'b1;
    t0 = cyc;
    @(posedge Clock); #1;
    iGPUCommitedResults = 1'b0;
  endtask

  // Starts a drain, then scrambles mask/count to prove they were sampled.
  task automatic run_drain(input logic [3:0] m, input logic [31:0] n, input int rmode,
                           input logic en, output int t0);
    begin_obs();
    ready_mode = rmode;
    iEnable    = en;
    iCoreMask  = m;
    iWordCount = n;
    if (en) add_expected(m, n);
    pulse_commit(t0);
    iCoreMask  = ~m;
    iWordCount = n + 32'd7;
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (done_q.size() < n && k < 3000) begin
      @(posedge Clock);
      k++;
    end
    check("done_timeout", 32'(done_q.size() >= n), 32'd1);
    repeat (3) @(posedge Clock);
    #1;
  endtask

  task automatic check_common(input string tag, input int nbeats, input int ndone);
    check({tag, "_beats"}, 32'(beat_q.size()), 32'(nbeats));
    check({tag, "_done_cnt"}, 32'(done_q.size()), 32'(ndone));
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_contig"}, 32'(busy_cnt), 32'(busy_last - busy_first + 1));
    if (done_q.size() > 0) check({tag, "_busy_end"}, 32'(busy_last), 32'(done_q[done_q.size()-1]));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(oResultValid), 32'd0);
    check({tag, "_busy"}, 32'(oBusy), 32'd0);
    check({tag, "_done"}, 32'(oDrainDone), 32'd0);
    check({tag, "_data"}, oResultData, 32'd0);
    check({tag, "_core"}, 32'(oResultCore), 32'd0);
    check({tag, "_addr"}, oResultAddress, 32'd0);
    check({tag, "_bank"}, 32'(oOMEMBankSelect), 32'd0);
    check({tag, "_radr"}, oOMEMReadAddress, 32'd0);
  endtask

  initial begin
    int t0, k;
    vecs[0] = '{mask: 4'b0001, count: 32'd3, rmode: 0, beats: 3};
    vecs[1] = '{mask: 4'b1010, count: 32'd2, rmode: 1, beats: 4};
    vecs[2] = '{mask: 4'b0000, count: 32'd3, rmode: 0, beats: 0};
    vecs[3] = '{mask: 4'b1111, count: 32'd0, rmode: 0, beats: 0};
    vecs[4] = '{mask: 4'b1001, count: 32'd1, rmode: 2, beats: 2};
    vecs[5] = '{mask: 4'b0110, count: 32'd4, rmode: 2, beats: 8};

    Reset = 1'b0;
    iEnable = 1'b0;
    iCoreMask = '0;
    iWordCount = '0;
    iGPUCommitedResults = 1'b0;
    busy_cnt = 0; busy_first = -1; busy_last = -1;
    repeat (3) @(posedge Clock);
    #1;
    check_outputs_zero("reset");
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;

    // Table-driven drains.
    for (int i = 0; i < 6; i++) begin
      run_drain(vecs[i].mask, vecs[i].count, vecs[i].rmode, 1'b1, t0);
      wait_done(1);
      check_common($sformatf("vec%0d", i), vecs[i].beats, 1);
    end

    // Start latency and per-word spacing with ready held high.
    run_drain(4'b0001, 32'd3, 0, 1'b1, t0);
    wait_done(1);
    check_common("lat", 3, 1);
    if (beat_q.size() == 3) begin
      check("lat_beat0", 32'(beat_q[0]), 32'(t0 + 4));
      check("lat_beat1", 32'(beat_q[1]), 32'(t0 + 7));
      check("lat_beat2", 32'(beat_q[2]), 32'(t0 + 10));
    end
    if (done_q.size() == 1) check("lat_done", 32'(done_q[0]), 32'(t0 + 12));
    check("lat_busy_first", 32'(busy_first), 32'(t0 + 1));

    // Empty drain: SCAN then DONE.
    run_drain(4'b0000, 32'd5, 0, 1'b1, t0);
    wait_done(1);
    if (done_q.size() == 1) check("empty_done", 32'(done_q[0]), 32'(t0 + 2));
    check("empty_busy_first", 32'(busy_first), 32'(t0 + 1));
    check("empty_busy_cnt", 32'(busy_cnt), 32'd2);
    check("empty_beats", 32'(beat_q.size()), 32'd0);

    // Disabled: commit edge must be ignored.
    run_drain(4'b1111, 32'd2, 0, 1'b0, t0);
    repeat (20) @(posedge Clock);
    #1;
    check("dis_beats", 32'(beat_q.size()), 32'd0);
    check("dis_done", 32'(done_q.size()), 32'd0);
    check("dis_busy", 32'(busy_cnt), 32'd0);
    iEnable = 1'b1;

    // Pending commit: two further edges mid-drain collapse into one restart
    // that samples the mask/count present at the end of the first drain.
    begin_obs();
    ready_mode = 0;
    iCoreMask  = 4'b1111;
    iWordCount = 32'd2;
    add_expected(4'b1111, 32'd2);
    add_expected(4'b0101, 32'd3);
    pulse_commit(t0);
    repeat (3) @(posedge Clock); #1;
    iCoreMask  = 4'b0101;
    iWordCount = 32'd3;
    pulse_commit(t0);
    @(posedge Clock); #1;
    pulse_commit(t0);
    wait_done(2);
    repeat (30) @(posedge Clock);
    #1;
    check_common("pend", 14, 2);

    // Stall in PUSH for 10 cycles, then reset mid-transfer.
    begin_obs();
    iCoreMask  = 4'b0100;
    iWordCount = 32'd2;
    add_expected(4'b0100, 32'd2);
    ready_mode = 3;
    pulse_commit(t0);
    k = 0;
    while (!oResultValid && k < 20) begin
      @(posedge Clock); #1;
      k++;
    end
    check("stall_reached", 32'(oResultValid), 32'd1);
    repeat (10) @(posedge Clock);
    #1;
    check("stall_valid", 32'(oResultValid), 32'd1);
    check("stall_core", 32'(oResultCore), 32'd2);
    check("stall_beats", 32'(beat_q.size()), 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    #1;
    check_outputs_zero("midrst");
    repeat (2) @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    run_drain(4'b0011, 32'd2, 0, 1'b1, t0);
    wait_done(1);
    check_common("postrst", 4, 1);

    // Randomized drains against the reference model.
    for (int i = 0; i < 12; i++) begin
      logic [3:0]  m;
      logic [31:0] n;
      int nb;
      m = 4'($urandom_range(0, 15));
      n = 32'($urandom_range(0, 4));
      nb = $countones(m) * int'(n);
      run_drain(m, n, 2, 1'b1, t0);
      wait_done(1);
      check_common($sformatf("rnd%0d", i), nb, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/omem_result_drain.md
# omem_result_drain

Result-drain engine for the host side of the GPU: the inverse path of the host's scene/instruction feeder. When the GPU commits results (RCOMMIT_O), the block walks the O-memory of every selected core via the GPU's OMBSEL_I/OMADR_I/OMEM_O read port and streams each word to the host over a valid/ready interface. After the drain it pulses a completion strobe that drives the GPU's STDONE_I.

## Interface
- WB_WIDTH, 32, data/address width (matches `WB_WIDTH)
- MAX_CORES, 4, number of cores/O-memory banks
- MAX_CORE_BITS, 2, log2(MAX_CORES)
- Clock  in  1  system clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low; asserted low clears all state immediately
- iEnable  in  1  block enable; commits ignored while low
- iCoreMask  in  MAX_CORES  cores to drain; sampled at drain start
- iWordCount  in  WB_WIDTH  words per core; sampled at drain start
- iGPUCommitedResults  in  1  GPU results-committed level (from RCOMMIT_O)
- oOMEMBankSelect  out  MAX_CORE_BITS  bank select to GPU OMBSEL_I
- oOMEMReadAddress  out  WB_WIDTH  word address to GPU OMADR_I
- iOMEMData  in  WB_WIDTH  GPU OMEM_O; valid exactly one cycle after address presented
- oResultData  out  WB_WIDTH  drained word
- oResultCore  out  MAX_CORE_BITS  core index of oResultData
- oResultAddress  out  WB_WIDTH  word address of oResultData
- oResultValid  out  1  stream valid
- iResultReady  in  1  stream ready from host
- oBusy  out  1  high from drain start until DONE exits
- oDrainDone  out  1  one-cycle pulse at drain completion (to STDONE_I)

## Operation
- Commit detection: register iGPUCommitedResults; start event = rising edge (current 1, previous 0) while iEnable=1.
- States: IDLE, SCAN, ISSUE, CAPTURE, PUSH, DONE.
- IDLE: on start event latch iCoreMask->mask, iWordCount->count, core=0, go SCAN.
- SCAN: if count==0 or no set bit in mask at index >= core -> DONE. Else core := lowest set index >= core, addr := 0, go ISSUE.
- ISSUE: drive oOMEMBankSelect=core, oOMEMReadAddress=addr; go CAPTURE.
- CAPTURE: register iOMEMData into oResultData, core into oResultCore, addr into oResultAddress; go PUSH.
- PUSH: oResultValid=1; outputs held stable until iResultReady=1. On handshake: if addr==count-1, core := core+1 and go SCAN (if core was MAX_CORES-1 -> DONE); else addr := addr+1, go ISSUE.
- DONE: oDrainDone=1 for one cycle, oBusy=0 next cycle; return to IDLE.
- Pending commit: a start event seen while not IDLE sets pending; on DONE exit with pending=1, clear it and restart directly into SCAN with freshly sampled mask/count (skipping IDLE). At most one pending is stored; extra events collapse.
- iEnable deasserted mid-drain does not abort; it only blocks new start events.
- Address arithmetic is unsigned WB_WIDTH; count-1 is computed only when count!=0, so there is no wrap.

## Timing
- Reset values: all outputs 0; state IDLE; pending 0; commit edge register 0.
- Start latency: rising edge of iGPUCommitedResults at cycle T -> SCAN at T+1, ISSUE at T+2, oResultValid at T+4.
- Per word: minimum 3 cycles (ISSUE, CAPTURE, PUSH with ready=1). Each ready-low cycle adds one.
- Core skip: one SCAN cycle per core transition regardless of gaps in the mask.
- oDrainDone asserts the cycle after the final handshake plus one SCAN cycle. With count==0 or mask==0: SCAN at T+1, DONE at T+2.
- oResultValid never drops without a handshake; data/core/address are constant while valid is high and ready is low.
- Reset low mid-transfer: outputs clear asynchronously and the in-flight word is discarded.

## Test plan
- mask=4'b0001, count=3, OMEM core0={A0,A1,A2}, ready=1 -> three beats (core0, addr 0,1,2, data A0..A2), 3 cycles apart; oDrainDone pulse; oBusy low afterward.
- mask=4'b1010, count=2, ready toggling 1/0 -> beats core1 addr0,1 then core3 addr0,1; data stable through ready-low cycles; no beats from cores 0/2.
- mask=0 or count=0, commit pulse -> no oResultValid; oDrainDone at T+2; oBusy high for exactly T+1..T+2.
- Second commit edge during a 4-core, count=2 drain -> first drain completes (8 beats, one done pulse), second drain starts with no IDLE gap and produces 8 more beats and a second pulse.
- iEnable=0 with a commit edge -> no activity; iResultReady=0 held for 10 cycles in PUSH -> valid held, values unchanged.
- Reset driven low while oResultValid=1 -> all outputs 0 within the same cycle; after release, a new commit edge drains from core 0, addr 0.
